// File: rtl/e203_ifu_jalr_sched_pkg.sv
// e203_ifu_jalr_sched_pkg: shared state/class encodings for the JALR target scheduler
package e203_ifu_jalr_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DEPW = 3'd1,
        ST_RDRF = 3'd2,
        ST_CAPT = 3'd3,
        ST_RESP = 3'd4
    } jalr_state_e;

    typedef enum logic [1:0] {
        CLS_X0 = 2'd0,
        CLS_X1 = 2'd1,
        CLS_XN = 2'd2
    } jalr_cls_e;

    localparam int unsigned RF_IDX_X0 = 0;
    localparam int unsigned RF_IDX_X1 = 1;

endpackage

// File: rtl/e203_ifu_jalr_cls.sv
// e203_ifu_jalr_cls: classify a JALR rs1 index as x0, x1 or a general register
module e203_ifu_jalr_cls
    import e203_ifu_jalr_sched_pkg::*;
#(
    parameter int RFIDX_WIDTH = 5
) (
    input  logic [RFIDX_WIDTH-1:0] rs1idx_i,
    output jalr_cls_e              cls_o
);

    assign cls_o = (rs1idx_i == RFIDX_WIDTH'(RF_IDX_X0)) ? CLS_X0 :
                   (rs1idx_i == RFIDX_WIDTH'(RF_IDX_X1)) ? CLS_X1 : CLS_XN;

endmodule

// File: rtl/e203_ifu_jalr_sched.sv
// e203_ifu_jalr_sched: resolves JALR targets, waiting out x1/xN dependencies and
// borrowing regfile read port 1 when the EXU leaves it idle.
module e203_ifu_jalr_sched
    import e203_ifu_jalr_sched_pkg::*;
#(
    parameter int PC_SIZE     = 32,
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5,
    parameter int STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [RFIDX_WIDTH-1:0] req_rs1idx,
    input  logic [XLEN-1:0]        req_imm,
    input  logic                   oitf_empty,
    input  logic                   ir_empty,
    input  logic                   ir_rs1en,
    input  logic                   ir_valid_clr,
    input  logic                   ir_rd_is_x1,
    input  logic                   exu_rs1_req,
    output logic                   rf_rs1_ena,
    output logic [RFIDX_WIDTH-1:0] rf_rs1_idx,
    input  logic [XLEN-1:0]        rf2bpu_x1,
    input  logic [XLEN-1:0]        rf2bpu_rs1,
    input  logic                   flush,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [PC_SIZE-1:0]     resp_target,
    output logic                   sched_busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    jalr_state_e             state_q, state_d;
    jalr_cls_e               cls_q, cls_d, req_cls;
    logic [RFIDX_WIDTH-1:0]  idx_q, idx_d;
    logic [XLEN-1:0]         imm_q, imm_d, x1_sum, rs1_sum;
    logic [PC_SIZE-1:0]      target_q, target_d;
    logic [STALL_CNT_W-1:0]  stall_q, stall_d;
    logic                    accept, dep_clr, stall_inc;

    e203_ifu_jalr_cls #(.RFIDX_WIDTH(RFIDX_WIDTH)) u_cls (
        .rs1idx_i (req_rs1idx),
        .cls_o    (req_cls)
    );

    assign accept    = (state_q == ST_IDLE) & req_valid & ~flush;
    assign dep_clr   = (cls_q == CLS_X1) ? (oitf_empty & ~ir_rd_is_x1)
                                         : (oitf_empty & (ir_empty | ir_valid_clr | ~ir_rs1en));
    assign stall_inc = ((state_q == ST_DEPW) & ~dep_clr) | ((state_q == ST_RDRF) & exu_rs1_req);
    // Carry out of the XLEN-bit add is dropped; the target keeps the low PC_SIZE bits
    assign x1_sum    = rf2bpu_x1 + imm_q;
    assign rs1_sum   = rf2bpu_rs1 + imm_q;

    assign req_ready   = (state_q == ST_IDLE);
    assign sched_busy  = (state_q != ST_IDLE);
    assign resp_valid  = (state_q == ST_RESP);
    assign rf_rs1_ena  = (state_q == ST_RDRF) & ~exu_rs1_req & ~flush;
    assign rf_rs1_idx  = (state_q == ST_RDRF) ? idx_q : '0;
    assign resp_target = target_q;
    assign stall_cnt   = stall_q;

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        idx_d    = idx_q;
        imm_d    = imm_q;
        target_d = target_q;
        stall_d  = stall_q + STALL_CNT_W'(stall_inc & ~&stall_q);
        case (state_q)
            ST_IDLE: if (accept) begin
                idx_d   = req_rs1idx;
                imm_d   = req_imm;
                cls_d   = req_cls;
                stall_d = '0;
                state_d = (req_cls == CLS_X0) ? ST_RESP : ST_DEPW;
                if (req_cls == CLS_X0) target_d = req_imm[PC_SIZE-1:0];
            end
            ST_DEPW: if (dep_clr) begin
                state_d = (cls_q == CLS_X1) ? ST_RESP : ST_RDRF;
                if (cls_q == CLS_X1) target_d = x1_sum[PC_SIZE-1:0];
            end
            ST_RDRF: state_d = exu_rs1_req ? ST_RDRF : ST_CAPT;
            ST_CAPT: begin
                target_d = rs1_sum[PC_SIZE-1:0];
                state_d  = ST_RESP;
            end
            ST_RESP: state_d = resp_ready ? ST_IDLE : ST_RESP;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cls_q    <= CLS_X0;
            idx_q    <= '0;
            imm_q    <= '0;
            target_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            idx_q    <= idx_d;
            imm_q    <= imm_d;
            target_q <= target_d;
            stall_q  <= stall_d;
        end
    end

endmodule
